// File: rtl/regfile_fwd_sb_pkg.sv
// Shared sizing defaults and forwarding-source indices for the bypassed GPR file.
// The ID-stage file, the bypass mux and the pipeline control all agree on these values.
package regfile_fwd_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREG_DEF   = 32;
  localparam int NRD_DEF    = 2;
  localparam int NFWD_DEF   = 3;

  // Youngest first: a lower index wins when several sources target one byte.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // Width of one forwarding source packed as {we, ok, addr, data, be}.
  function automatic int fwd_bus_w(input int data_w, input int addr_w);
    return 1 + 1 + addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_fwd_sb_if.sv
// Decode-side read ports, WB write port and bypass sources of the GPR file.
// Master is the pipeline; slave is the register file.
interface regfile_fwd_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NFWD   = 3
);
  logic [NRD*ADDR_W-1:0]    raddr;
  logic [NRD*DATA_W-1:0]    rdata;
  logic [NRD-1:0]           rd_stall;
  logic                     stall_any;
  logic [NRD-1:0]           rd_en;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W/8-1:0]      wbe;
  logic [DATA_W-1:0]        wdata;
  logic [NFWD-1:0]          fwd_we;
  logic [NFWD-1:0]          fwd_ok;
  logic [NFWD*ADDR_W-1:0]   fwd_addr;
  logic [NFWD*DATA_W-1:0]   fwd_data;
  logic [NFWD*DATA_W/8-1:0] fwd_be;
  logic [31:0]              wr_count;

  modport master (
    output raddr, rd_en, we, waddr, wbe, wdata,
           fwd_we, fwd_ok, fwd_addr, fwd_data, fwd_be,
    input  rdata, rd_stall, stall_any, wr_count
  );

  modport slave (
    input  raddr, rd_en, we, waddr, wbe, wdata,
           fwd_we, fwd_ok, fwd_addr, fwd_data, fwd_be,
    output rdata, rd_stall, stall_any, wr_count
  );
endinterface

// File: rtl/regfile_fwd_sb_fwd_byte_mux.sv
// Per-byte bypass merge for one read port: youngest matching source wins each byte,
// and a not-yet-ready winner raises the hazard bit.
module fwd_byte_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NFWD   = 3
) (
  input  logic [ADDR_W-1:0]        i_raddr,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_base,
  input  logic [NFWD-1:0]          i_fwd_we,
  input  logic [NFWD-1:0]          i_fwd_ok,
  input  logic [NFWD*ADDR_W-1:0]   i_fwd_addr,
  input  logic [NFWD*DATA_W-1:0]   i_fwd_data,
  input  logic [NFWD*DATA_W/8-1:0] i_fwd_be,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_stall
);
  localparam int NB = DATA_W / 8;

  logic [NB-1:0] w_hit;

  always_comb begin
    o_data  = i_base;
    o_stall = 1'b0;
    w_hit   = '0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NFWD; k++) begin
        // i_en is low for r0, so sources aimed at r0 can never match.
        if (i_en && !w_hit[b] && i_fwd_we[k] && i_fwd_be[k*NB + b] &&
            (i_fwd_addr[k*ADDR_W +: ADDR_W] == i_raddr)) begin
          w_hit[b]         = 1'b1;
          o_data[b*8 +: 8] = i_fwd_data[k*DATA_W + b*8 +: 8];
          if (!i_fwd_ok[k]) o_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// ID-stage GPR file: byte-enable WB write port, zero-latency bypassed read ports,
// per-port hazard stall and a saturating committed-write counter.
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NFWD   = NFWD_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_fwd_sb_if.slave bus
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [31:0]       r_wr_count;
  logic              w_wr_ok;

  assign w_wr_ok = bus.we && (bus.waddr != '0) && (32'(bus.waddr) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_wr_count <= '0;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wbe[b]) r_mem[bus.waddr][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
      if (r_wr_count != '1) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign bus.wr_count = r_wr_count;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_valid;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_merged;
    logic              w_hz;

    assign w_ra    = bus.raddr[i*ADDR_W +: ADDR_W];
    assign w_valid = (w_ra != '0) && (32'(w_ra) < NREG);
    assign w_base  = w_valid ? r_mem[w_ra] : '0;

    fwd_byte_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NFWD   (NFWD)
    ) u_fwd_byte_mux (
      .i_raddr    (w_ra),
      .i_en       (w_valid),
      .i_base     (w_base),
      .i_fwd_we   (bus.fwd_we),
      .i_fwd_ok   (bus.fwd_ok),
      .i_fwd_addr (bus.fwd_addr),
      .i_fwd_data (bus.fwd_data),
      .i_fwd_be   (bus.fwd_be),
      .o_data     (w_merged),
      .o_stall    (w_hz)
    );

    assign bus.rdata[i*DATA_W +: DATA_W] = w_valid ? w_merged : '0;
    assign bus.rd_stall[i]               = w_hz;
  end

  assign bus.stall_any = |(bus.rd_stall & bus.rd_en);

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: expectations are queued as stimulus is applied
// and drained against the combinational outputs one time unit later.
module tb_regfile_fwd_sb;
  import regfile_fwd_sb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  typedef enum {K_RD0, K_RD1, K_ST0, K_ANY, K_CNT} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_fwd_sb_if bus ();

  regfile_fwd_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_mem [NR];
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD0: chk(e.tag, bus.rdata[31:0], e.exp);
        K_RD1: chk(e.tag, bus.rdata[63:32], e.exp);
        K_ST0: chk(e.tag, {31'd0, bus.rd_stall[0]}, e.exp);
        K_ANY: chk(e.tag, {31'd0, bus.stall_any}, e.exp);
        default: chk(e.tag, bus.wr_count, e.exp);
      endcase
    end
  endtask

  task automatic clr_fwd();
    bus.fwd_we   = '0;
    bus.fwd_ok   = '0;
    bus.fwd_addr = '0;
    bus.fwd_data = '0;
    bus.fwd_be   = '0;
  endtask

  task automatic set_fwd(input int k, input logic ok, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
    bus.fwd_we[k]           = 1'b1;
    bus.fwd_ok[k]           = ok;
    bus.fwd_addr[k*AW +: AW] = a;
    bus.fwd_data[k*DW +: DW] = d;
    bus.fwd_be[k*4 +: 4]     = be;
  endtask

  task automatic m_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = a; bus.wbe = be; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
    if (a != 0) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.raddr = '0; bus.rd_en = '0; bus.we = 1'b0; bus.waddr = '0;
    bus.wbe = '0; bus.wdata = '0;
    clr_fwd();
    model_reset();
    #1 rst = 1'b1;

    // Reset: every register reads 0 on both ports while reset is held.
    for (int r = 1; r < NR; r++) begin
      bus.raddr[AW-1:0]  = AW'(r);
      bus.raddr[2*AW-1:AW] = AW'(NR - r);
      push("rst_rd0", K_RD0, 32'h0);
      push("rst_rd1", K_RD1, 32'h0);
      drain();
    end
    push("rst_cnt", K_CNT, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Reset arriving during a write cycle discards the write.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wbe = 4'hF; bus.wdata = 32'hDEADBEEF;
    #2 rst = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    rst = 1'b0;
    bus.raddr[AW-1:0] = 5'd5;
    push("midwr_r5", K_RD0, 32'h0);
    push("midwr_cnt", K_CNT, 32'h0);
    drain();

    // Reset clears committed data asynchronously, between clock edges.
    m_write(5'd6, 4'hF, 32'h12345678);
    bus.raddr[AW-1:0] = 5'd6;
    push("pre_async_r6", K_RD0, m_mem[6]);
    push("pre_async_cnt", K_CNT, m_cnt);
    drain();
    #2 rst = 1'b1;
    model_reset();
    push("async_r6", K_RD0, 32'h0);
    push("async_cnt", K_CNT, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Byte-enable writes.
    m_write(5'd3, 4'hF, 32'h11223344);
    m_write(5'd3, 4'b0101, 32'hAABBCCDD);
    bus.raddr[AW-1:0] = 5'd3;
    push("bytewr_r3", K_RD0, 32'h11BB33DD);
    push("bytewr_model", K_RD0, m_mem[3]);
    push("bytewr_cnt", K_CNT, 32'd2);
    drain();

    // Forwarding priority EX > MEM > WB.
    clr_fwd();
    set_fwd(FWD_EX, 1'b1, 5'd7, 32'h1, 4'hF);
    set_fwd(FWD_MEM, 1'b1, 5'd7, 32'h2, 4'hF);
    set_fwd(FWD_WB, 1'b1, 5'd7, 32'h3, 4'hF);
    bus.raddr[AW-1:0] = 5'd7;
    push("fwd_ex", K_RD0, 32'h1);
    push("fwd_ex_st", K_ST0, 32'h0);
    drain();
    bus.fwd_we[FWD_EX] = 1'b0;
    push("fwd_mem", K_RD0, 32'h2);
    drain();
    bus.fwd_we[FWD_MEM] = 1'b0;
    push("fwd_wb", K_RD0, 32'h3);
    drain();

    // Load-use hazard: younger not-ready source shadows an older ready one.
    clr_fwd();
    set_fwd(FWD_EX, 1'b0, 5'd4, 32'h0, 4'hF);
    set_fwd(FWD_MEM, 1'b1, 5'd4, 32'h55, 4'hF);
    bus.raddr = {5'd1, 5'd4};
    bus.rd_en = 2'b01;
    push("lu_stall0", K_ST0, 32'h1);
    push("lu_any", K_ANY, 32'h1);
    drain();
    bus.rd_en = 2'b00;
    push("lu_any_masked", K_ANY, 32'h0);
    drain();
    bus.raddr = {5'd4, 5'd1};
    bus.rd_en = 2'b10;
    push("lu_port1_any", K_ANY, 32'h1);
    push("lu_port0_clean", K_ST0, 32'h0);
    drain();
    bus.fwd_ok[FWD_EX] = 1'b1;
    push("lu_resolved_any", K_ANY, 32'h0);
    drain();
    bus.rd_en = 2'b00;
    clr_fwd();

    // Partial forwarding merges source bytes with the array value.
    m_write(5'd9, 4'hF, 32'hAAAAAAAA);
    set_fwd(FWD_MEM, 1'b1, 5'd9, 32'h00001234, 4'b0011);
    bus.raddr[AW-1:0] = 5'd9;
    push("part_rd", K_RD0, 32'hAAAA1234);
    push("part_st", K_ST0, 32'h0);
    drain();
    set_fwd(FWD_EX, 1'b0, 5'd9, 32'h77000000, 4'b1000);
    push("part_ex_pending", K_ST0, 32'h1);
    drain();
    clr_fwd();

    // Register 0 ignores writes and forwarding.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wbe = 4'hF; bus.wdata = 32'hFFFFFFFF;
    set_fwd(FWD_EX, 1'b0, 5'd0, 32'hFFFFFFFF, 4'hF);
    bus.raddr[AW-1:0] = 5'd0;
    bus.rd_en = 2'b01;
    push("r0_rd", K_RD0, 32'h0);
    push("r0_st", K_ST0, 32'h0);
    push("r0_any", K_ANY, 32'h0);
    drain();
    @(negedge clk);
    bus.we = 1'b0;
    clr_fwd();
    bus.rd_en = 2'b00;
    push("r0_rd_after", K_RD0, 32'h0);
    push("r0_cnt", K_CNT, m_cnt);
    drain();

    // Same-cycle write and read: pre-write value unless WB forwards it.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wbe = 4'hF; bus.wdata = 32'hCAFEF00D;
    bus.raddr[AW-1:0] = 5'd3;
    push("samecyc_old", K_RD0, 32'h11BB33DD);
    drain();
    set_fwd(FWD_WB, 1'b1, 5'd3, 32'hCAFEF00D, 4'hF);
    push("samecyc_wb", K_RD0, 32'hCAFEF00D);
    drain();
    @(negedge clk);
    bus.we = 1'b0;
    clr_fwd();
    m_mem[3] = 32'hCAFEF00D;
    m_cnt++;
    push("samecyc_new", K_RD0, m_mem[3]);
    push("samecyc_cnt", K_CNT, m_cnt);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
- Parametrised successor to the pipeline's two-read/one-write GPR file with EX/MEM/WB bypass.
- Generalised in data width, register count, number of read ports and number of forwarding sources.
- Adds byte-enable writes, asynchronous reset-to-zero of the array, and per-source data-ready bits. The ready bits produce a per-port hazard stall for load-use and multi-cycle producers.
- Sits in ID: it is read combinationally by decode and written by WB. Stall outputs feed the pipeline control stall request.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NREG, 32, number of architectural registers. Index 0 is hard-wired zero.
- ADDR_W, 5, register index width; must satisfy NREG <= 2**ADDR_W.
- NRD, 2, number of combinational read ports.
- NFWD, 3, number of forwarding sources. Index 0 is the youngest (EX), then MEM, then WB.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset; clears the whole array to 0.
- raddr  in  NRD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data, one slice per port.
- rd_stall  out  NRD  port i needs a value that is not yet produced.
- stall_any  out  1  OR of rd_stall, masked by rd_en.
- rd_en  in  NRD  port i is actually used by the current instruction.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wbe  in  DATA_W/8  byte enables for the write.
- wdata  in  DATA_W  write data.
- fwd_we  in  NFWD  source k will write a register.
- fwd_ok  in  NFWD  source k data is valid this cycle (0 = load or multicycle op still pending).
- fwd_addr  in  NFWD*ADDR_W  destination register of source k.
- fwd_data  in  NFWD*DATA_W  data of source k.
- fwd_be  in  NFWD*DATA_W/8  byte enables of source k.
- wr_count  out  32  number of committed writes since reset, excluding writes to register 0; saturates at 2**32-1.

Behaviour:
- Reset (rst=1, asynchronous):
  - All registers become 0 and wr_count becomes 0.
  - rdata reflects the zero array immediately, subject to forwarding.
  - Reset mid-write: the write is discarded.
- Write: on posedge clk with we=1 and waddr!=0 and waddr<NREG, each byte b with wbe[b]=1 takes wdata byte b; other bytes are unchanged.
  - A write to index 0 or to an index >= NREG is ignored and does not count.
  - wr_count increments by 1 per counted write cycle.
- Read port i, evaluated combinationally with zero latency:
  - raddr==0 or raddr>=NREG: rdata=0 and rd_stall=0.
  - Otherwise the base value is the array entry.
  - For each byte, the youngest source k with fwd_we[k]=1, fwd_addr[k]==raddr and fwd_be[k][b]=1 supplies byte b. That is, search k = 0..NFWD-1 and take the first hit per byte.
  - If the youngest matching source for any byte has fwd_ok=0, rd_stall[i]=1; rdata is don't-care but must be X-free.
  - Older matching sources never override a younger match, even when the younger one is not ok.
- Same-cycle write and read of the same register: rdata shows the pre-write array value, corrected by forwarding. The WB forwarding source covers this case.
- Sources with fwd_addr==0 are ignored for forwarding.
- stall_any = OR over i of (rd_stall[i] & rd_en[i]).
- No internal state besides the array and wr_count; there is no pipeline latency.

Decomposition:
- Shared defines header, extending the existing one:
  - DATA_W, ADDR_W, NFWD defaults.
  - Per-source bus width macro: 1+1+ADDR_W+DATA_W+DATA_W/8.
  - Source index constants FWD_EX=0, FWD_MEM=1, FWD_WB=2.
- One sub-module, fwd_byte_mux. It takes one read address plus all sources and returns the merged byte data and a hazard bit. It is instantiated NRD times via generate.
- The array, write logic and counter stay in the top module.

Test Plan:
- Reset then read: assert rst; read r1..r31 → all 0; wr_count=0. Assert rst mid-write of r5=0xDEADBEEF → r5 reads 0 after rst is released.
- Byte write: write r3=0x11223344 (wbe=4'hF), then r3=0xAABBCCDD with wbe=4'b0101 → r3=0x11BB33DD; wr_count=2.
- Forward priority: EX r7=0x1, MEM r7=0x2, WB r7=0x3, all ok → rdata=0x1. Remove EX → 0x2. Remove MEM → 0x3.
- Load-use hazard: EX r4 with fwd_ok=0, MEM r4=0x55 ok, raddr0=4, rd_en0=1 → rd_stall[0]=1, stall_any=1. Repeat with rd_en0=0 → stall_any=0.
- Partial forward: array r9=0xAAAAAAAA; MEM r9 be=4'b0011, data 0x00001234 → rdata=0xAAAA1234, no stall.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; EX fwd to r0 → r0 reads 0, wr_count unchanged, rd_stall=0.
